uart_rx: RTL

UART receiver, the companion of uart_tx on the same serial link. Deserialises an asynchronous idle-high line: one start bit, 8 or 9 data bits LSB first, 1 or 2 stop bits, no parity. Uses the same baud divisor and frame-format configuration fields as the transmitter, so a looped-back uart_tx/uart_rx pair with identical config exchanges words losslessly. Delivers each received word as a one-cycle valid pulse with status flags to the register/FIFO layer above.

---
 rtl/uart_rx_pkg.sv | 34 +++
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_bit_sync.sv | 23 ++
 rtl/uart_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receive-side types and constants.
package uart_rx_pkg;

    localparam int unsigned UART_BR_DIV_W = 16;
    localparam int unsigned UART_MAX_WORD = 9;
    localparam int unsigned UART_MIN_DIV  = 2;

    // Field layout identical to the transmitter's configuration word.
    typedef struct packed {
        logic [UART_BR_DIV_W-1:0] br_div;
        logic                     word;
        logic                     stop;
        logic                     en;
    } rx_config_t;

    typedef rx_config_t uart_config_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RESYNC
    } rx_state_e;

    // Clamp a programmed divisor to the smallest usable value.
    function automatic logic [UART_BR_DIV_W-1:0] eff_div(input logic [UART_BR_DIV_W-1:0] br_div);
        if (br_div < UART_BR_DIV_W'(UART_MIN_DIV)) begin
            return UART_BR_DIV_W'(UART_MIN_DIV);
        end
        return br_div;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Bundle of the receiver's config, line and delivery signals.
interface uart_rx_if
    import uart_rx_pkg::*;
(
    input logic clk
);
    logic                     rst;
    rx_config_t               rx_cfg;
    logic                     rx;
    logic [UART_MAX_WORD-1:0] data;
    logic                     valid;
    logic                     frame_err;
    logic                     break_det;
    logic                     idle;

    modport dut (
        input  clk, rst, rx_cfg, rx,
        output data, valid, frame_err, break_det, idle
    );

    modport host (
        input  clk, data, valid, frame_err, break_det, idle,
        output rst, rx_cfg, rx
    );
endinterface

// File: rtl/uart_bit_sync.sv
// Flop chain bringing an asynchronous, idle-high line into the clk domain.
module uart_bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop deserialiser with framing error and break detection.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned BR_DIV_W    = UART_BR_DIV_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  rx_config_t               rx_cfg,
    input  logic                     rx,
    output logic [UART_MAX_WORD-1:0] data,
    output logic                     valid,
    output logic                     frame_err,
    output logic                     break_det,
    output logic                     idle
);

    logic rx_s;
    logic rx_prev;

    uart_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    rx_state_e                state, state_n;
    logic [BR_DIV_W-1:0]      cnt, cnt_n;
    logic [BR_DIV_W-1:0]      div_l, div_n;
    logic [3:0]               idx, idx_n;
    logic                     stop_cnt, stop_cnt_n;
    logic [UART_MAX_WORD-1:0] shreg, shreg_n;
    logic                     err, err_n;
    logic                     first_lo, first_lo_n;
    logic                     word_l, word_n;
    logic                     stop_l, stop_n;
    logic [UART_MAX_WORD-1:0] data_n;
    logic                     valid_n, fe_n, brk_n, idle_n;

    logic [BR_DIV_W-1:0]      div_eff;
    logic [BR_DIV_W-1:0]      half_m1;
    logic [BR_DIV_W-1:0]      div_m1;
    logic [3:0]               last_idx;
    logic [UART_MAX_WORD-1:0] word_data;

    assign div_eff   = BR_DIV_W'(eff_div(rx_cfg.br_div));
    assign half_m1   = (div_l >> 1) - BR_DIV_W'(1);
    assign div_m1    = div_l - BR_DIV_W'(1);
    assign last_idx  = word_l ? 4'd8 : 4'd7;
    assign word_data = word_l ? shreg : {1'b0, shreg[7:0]};

    // Next-state and delivery logic; sample points are counted from the synchronised start edge.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        div_n      = div_l;
        idx_n      = idx;
        stop_cnt_n = stop_cnt;
        shreg_n    = shreg;
        err_n      = err;
        first_lo_n = first_lo;
        word_n     = word_l;
        stop_n     = stop_l;
        data_n     = data;
        valid_n    = 1'b0;
        fe_n       = frame_err;
        brk_n      = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s && rx_prev) begin
                    state_n    = START;
                    cnt_n      = '0;
                    idx_n      = '0;
                    stop_cnt_n = 1'b0;
                    shreg_n    = '0;
                    err_n      = 1'b0;
                    first_lo_n = 1'b0;
                    div_n      = div_eff;
                    word_n     = rx_cfg.word;
                    stop_n     = rx_cfg.stop;
                end
            end
            START: begin
                if (cnt == half_m1) begin
                    cnt_n = '0;
                    idx_n = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + BR_DIV_W'(1);
                end
            end
            DATA: begin
                if (cnt == div_m1) begin
                    shreg_n[idx] = rx_s;
                    cnt_n        = '0;
                    idx_n        = idx + 4'd1;
                    if (idx == last_idx) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + BR_DIV_W'(1);
                end
            end
            STOP: begin
                if (cnt == div_m1) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        err_n = 1'b1;
                    end
                    if (!stop_cnt && !rx_s) begin
                        first_lo_n = 1'b1;
                    end
                    if (stop_cnt == stop_l) begin
                        valid_n = 1'b1;
                        data_n  = word_data;
                        fe_n    = err | !rx_s;
                        brk_n   = (word_data == '0) && (stop_cnt ? first_lo : !rx_s);
                        state_n = (err | !rx_s) ? RESYNC : IDLE;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + BR_DIV_W'(1);
                end
            end
            RESYNC: begin
                // Wait for the line to return high so a stuck-low line is one frame only.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (!rx_cfg.en) begin
            state_n = IDLE;
            valid_n = 1'b0;
            brk_n   = 1'b0;
            data_n  = data;
            fe_n    = frame_err;
        end

        idle_n = (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rx_prev   <= 1'b1;
            cnt       <= '0;
            div_l     <= BR_DIV_W'(UART_MIN_DIV);
            idx       <= '0;
            stop_cnt  <= 1'b0;
            shreg     <= '0;
            err       <= 1'b0;
            first_lo  <= 1'b0;
            word_l    <= 1'b0;
            stop_l    <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            break_det <= 1'b0;
            idle      <= 1'b1;
        end else begin
            state     <= state_n;
            rx_prev   <= rx_s;
            cnt       <= cnt_n;
            div_l     <= div_n;
            idx       <= idx_n;
            stop_cnt  <= stop_cnt_n;
            shreg     <= shreg_n;
            err       <= err_n;
            first_lo  <= first_lo_n;
            word_l    <= word_n;
            stop_l    <= stop_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= fe_n;
            break_det <= brk_n;
            idle      <= idle_n;
        end
    end

endmodule
